// File: rtl/button_debouncer_multi_pkg.sv
// Shared definitions for the multi-button debouncer.
//   - debounce_state_e : per-channel FSM state and its 2-bit encoding
//   - cnt_width/max_u  : counter width helpers (never return a zero width)
//   - DEF_*            : default timing constants for a 12 MHz clock
package debounce_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StLong    = 2'd2,
        StRepeat  = 2'd3
    } debounce_state_e;

    localparam int unsigned DEF_NUM_BUTTONS   = 4;
    localparam int unsigned DEF_HOLD_CYCLES   = 65536;     // ~5.4 ms
    localparam int unsigned DEF_LONG_CYCLES   = 12000000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES = 2400000;   // 200 ms

    // Bits needed to hold the values 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer_multi_if.sv
// Pin-side and event-side signals of the debouncer.
//   buttons_in      raw active-high pins
//   button_state    debounced level per button
//   button_pressed  1-cycle pulse on accepted 0->1
//   button_released 1-cycle pulse on accepted 1->0
//   button_long     1-cycle pulse after a long hold
//   button_repeat   1-cycle auto-repeat pulse
//   any_event       OR of all pulses, same cycle
// master: drives the pins (board / bench); slave: the debouncer.
interface button_debouncer_multi_if #(
    parameter int unsigned NUM_BUTTONS = 4
);
    logic [NUM_BUTTONS-1:0] buttons_in;
    logic [NUM_BUTTONS-1:0] button_state;
    logic [NUM_BUTTONS-1:0] button_pressed;
    logic [NUM_BUTTONS-1:0] button_released;
    logic [NUM_BUTTONS-1:0] button_long;
    logic [NUM_BUTTONS-1:0] button_repeat;
    logic                   any_event;

    modport master (
        output buttons_in,
        input  button_state,
        input  button_pressed,
        input  button_released,
        input  button_long,
        input  button_repeat,
        input  any_event
    );

    modport slave (
        input  buttons_in,
        output button_state,
        output button_pressed,
        output button_released,
        output button_long,
        output button_repeat,
        output any_event
    );
endinterface

// File: rtl/button_debouncer_multi_channel.sv
// One debouncer channel: 2-flop synchroniser, stable counter, hold/repeat
// counter and press FSM. All outputs are registered.
//   clk, reset       clock, asynchronous active-high reset
//   button_in        raw pin
//   button_state     debounced level
//   button_pressed   / button_released / button_long / button_repeat pulses
//   event_next       OR of the pulse next-states, for the top-level any_event flop
// Optional feature: define DEBOUNCE_AUTO_REPEAT_EN to enable auto-repeat.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_state,
    output logic button_pressed,
    output logic button_released,
    output logic button_long,
    output logic button_repeat,
    output logic event_next
);

    localparam int unsigned STABLE_W = cnt_width(HOLD_CYCLES);
    localparam int unsigned HOLD_W   = cnt_width(max_u(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [HOLD_W-1:0]   REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
`endif

    logic [1:0]          sync_q;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic                level_q, level_d;
    debounce_state_e     fsm_q, fsm_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                pressed_q, pressed_d;
    logic                released_q, released_d;
    logic                long_q, long_d;
    logic                repeat_d;
    logic                accept;

    // sync_q[1] is the sample s; sync_q[0] is the value s takes on the next
    // edge, so comparing them clears the counter on the edge s changes.
    always_comb begin
        stable_d = stable_q;
        if (sync_q[0] != sync_q[1]) begin
            stable_d = '0;
        end else if (stable_q != STABLE_LAST) begin
            stable_d = stable_q + STABLE_W'(1);
        end
    end

    assign accept  = (stable_q == STABLE_LAST) && (sync_q[1] != level_q);
    assign level_d = accept ? sync_q[1] : level_q;

    always_comb begin
        fsm_d      = fsm_q;
        hold_d     = hold_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        if (accept && !sync_q[1]) begin
            // Release takes priority over a long or repeat threshold.
            fsm_d      = StIdle;
            hold_d     = '0;
            released_d = 1'b1;
        end else begin
            case (fsm_q)
                StIdle: begin
                    if (accept) begin
                        fsm_d     = StPressed;
                        hold_d    = '0;
                        pressed_d = 1'b1;
                    end
                end
                StPressed: begin
                    if (hold_q == LONG_LAST) begin
                        fsm_d  = StLong;
                        hold_d = '0;
                        long_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                StLong, StRepeat: begin
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                    fsm_d = StRepeat;
                    if (hold_q == REPEAT_LAST) begin
                        hold_d   = '0;
                        repeat_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
`else
                    fsm_d = StLong;  // parks here until release
`endif
                end
                default: fsm_d = StIdle;
            endcase
        end
    end

    assign event_next = pressed_d | released_d | long_d | repeat_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            stable_q   <= '0;
            level_q    <= 1'b0;
            fsm_q      <= StIdle;
            hold_q     <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], button_in};
            stable_q   <= stable_d;
            level_q    <= level_d;
            fsm_q      <= fsm_d;
            hold_q     <= hold_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            long_q     <= long_d;
        end
    end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    logic repeat_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign button_repeat = repeat_q;
`else
    assign button_repeat = 1'b0;
`endif

    assign button_state    = level_q;
    assign button_pressed  = pressed_q;
    assign button_released = released_q;
    assign button_long     = long_q;

endmodule

// File: rtl/button_debouncer_multi.sv
// Multi-button debouncer top: NUM_BUTTONS independent debounce_channel
// instances plus the registered any_event OR.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    button_debouncer_multi_if.slave (pins in, levels and pulses out)
// Optional feature: define DEBOUNCE_AUTO_REPEAT_EN to enable auto-repeat.
module button_debouncer_multi
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS   = DEF_NUM_BUTTONS,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input logic                      clk,
    input logic                      reset,
    button_debouncer_multi_if.slave  bus
);

    logic [NUM_BUTTONS-1:0] state_w;
    logic [NUM_BUTTONS-1:0] pressed_w;
    logic [NUM_BUTTONS-1:0] released_w;
    logic [NUM_BUTTONS-1:0] long_w;
    logic [NUM_BUTTONS-1:0] repeat_w;
    logic [NUM_BUTTONS-1:0] event_w;
    logic                   any_event_q;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .button_in      (bus.buttons_in[i]),
            .button_state   (state_w[i]),
            .button_pressed (pressed_w[i]),
            .button_released(released_w[i]),
            .button_long    (long_w[i]),
            .button_repeat  (repeat_w[i]),
            .event_next     (event_w[i])
        );
    end

    // Registered from the channels' pulse next-states so it lines up with them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_event_q <= 1'b0;
        end else begin
            any_event_q <= |event_w;
        end
    end

    assign bus.button_state    = state_w;
    assign bus.button_pressed  = pressed_w;
    assign bus.button_released = released_w;
    assign bus.button_long     = long_w;
    assign bus.button_repeat   = repeat_w;
    assign bus.any_event       = any_event_q;

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Bench for button_debouncer_multi: directed scenarios with literal checks,
// then random pin activity, all compared every cycle against a time-based
// behavioural model. Define DEBOUNCE_AUTO_REPEAT_EN to cover auto-repeat.
module tb_button_debouncer_multi;

    localparam int NB = 2;
    localparam int H  = 8;
    localparam int L  = 32;
    localparam int R  = 10;

    logic clk = 1'b0;
    logic reset;
    bit   checking = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    button_debouncer_multi_if #(.NUM_BUTTONS(NB)) bus ();

    button_debouncer_multi #(
        .NUM_BUTTONS  (NB),
        .HOLD_CYCLES  (H),
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- behavioural model ----------------
    // samp[c][j] = pin value sampled j edges ago. A level is accepted once the
    // synchronised sample (2 edges behind the pin) has held the same value for
    // H consecutive samples and differs from the current level.
    bit          samp [NB][H+2];
    bit          m_state [NB];
    int          press_t [NB];
    int          long_t [NB];
    logic [NB-1:0] e_state, e_pr, e_rl, e_lg, e_rp;
    logic          e_any;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            for (int c = 0; c < NB; c++) begin
                for (int j = 0; j < H + 2; j++) samp[c][j] = 1'b0;
                m_state[c] = 1'b0;
                press_t[c] = 0;
                long_t[c]  = -1;
            end
            e_state = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0; e_any = 1'b0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                bit stable;
                e_pr[c] = 1'b0; e_rl[c] = 1'b0; e_lg[c] = 1'b0; e_rp[c] = 1'b0;
                for (int j = H + 1; j > 0; j--) samp[c][j] = samp[c][j-1];
                samp[c][0] = bus.buttons_in[c];
                stable = 1'b1;
                for (int j = 3; j < H + 2; j++) if (samp[c][j] != samp[c][2]) stable = 1'b0;
                if (stable && samp[c][2] != m_state[c]) begin
                    m_state[c] = samp[c][2];
                    long_t[c]  = -1;
                    if (m_state[c]) begin
                        e_pr[c]    = 1'b1;
                        press_t[c] = cyc;
                    end else begin
                        e_rl[c] = 1'b1;
                    end
                end else if (m_state[c]) begin
                    if (long_t[c] < 0 && cyc - press_t[c] == L) begin
                        e_lg[c]   = 1'b1;
                        long_t[c] = cyc;
                    end
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                    else if (long_t[c] >= 0 && (cyc - long_t[c]) % R == 0) begin
                        e_rp[c] = 1'b1;
                    end
`endif
                end
                e_state[c] = m_state[c];
            end
            e_any = |{e_pr, e_rl, e_lg, e_rp};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [5*NB:0] got_v, want_v;

    always @(negedge clk) begin
        if (checking) begin
            got_v = {bus.button_state, bus.button_pressed, bus.button_released,
                     bus.button_long, bus.button_repeat, bus.any_event};
            want_v = reset ? '0 : {e_state, e_pr, e_rl, e_lg, e_rp, e_any};
            n_total++;
            if (got_v === want_v) n_pass++;
            else $display("FAIL outputs cyc=%0d got=%b expected=%b", cyc, got_v, want_v);
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_bits(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #2 reset = 1'b1;
        step(n);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.buttons_in = '0;
        step(1);
        checking = 1'b1;
        step(2);
        #2 reset = 1'b0;
        step(3);
        expect_bits("reset_outputs", 32'(got_v), 32'd0);

        // Clean press on ch0: accepted exactly 10 cycles after the pin edge.
        bus.buttons_in[0] = 1'b1;
        step(9);
        expect_bits("press_latency_minus1", 32'(bus.button_state), 32'd0);
        step(1);
        expect_bits("press_state", 32'(bus.button_state), 32'd1);
        expect_bits("press_pulse", 32'(bus.button_pressed), 32'd1);
        expect_bits("press_any", 32'(bus.any_event), 32'd1);
        step(1);
        expect_bits("press_pulse_width", 32'(bus.button_pressed), 32'd0);

        // Reset with ch0 still held: outputs clear, no release, re-accept later.
        step(5);
        #2 reset = 1'b1;
        step(1);
        expect_bits("reset_mid_press", 32'({bus.button_state, bus.button_pressed,
                    bus.button_released, bus.button_long, bus.any_event}), 32'd0);
        step(1);
        #2 reset = 1'b0;
        step(9);
        expect_bits("after_reset_state", 32'(bus.button_state), 32'd0);
        expect_bits("after_reset_no_release", 32'(bus.button_released), 32'd0);
        step(1);
        expect_bits("reaccept_state", 32'(bus.button_state), 32'd1);
        expect_bits("reaccept_pulse", 32'(bus.button_pressed), 32'd1);

        // Release ch0, then bounce it every 5 cycles: never accepted.
        bus.buttons_in[0] = 1'b0;
        step(12);
        for (int i = 0; i < 20; i++) begin
            bus.buttons_in[0] = ~bus.buttons_in[0];
            step(5);
            expect_bits("bounce_state", 32'(bus.button_state[0]), 32'd0);
        end

        // ch1 long press and release.
        bus.buttons_in[1] = 1'b1;
        step(10);
        expect_bits("ch1_press", 32'(bus.button_pressed), 32'd2);
        step(31);
        expect_bits("ch1_long_early", 32'(bus.button_long), 32'd0);
        step(1);
        expect_bits("ch1_long", 32'(bus.button_long), 32'd2);
        step(1);
        expect_bits("ch1_long_once", 32'(bus.button_long), 32'd0);
        step(17);
        bus.buttons_in[1] = 1'b0;
        step(10);
        expect_bits("ch1_release", 32'(bus.button_released), 32'd2);
        step(5);

`ifdef DEBOUNCE_AUTO_REPEAT_EN
        bus.buttons_in[0] = 1'b1;
        step(10);
        expect_bits("rep_press", 32'(bus.button_pressed), 32'd1);
        step(32);
        expect_bits("rep_long", 32'(bus.button_long), 32'd1);
        step(9);
        expect_bits("rep_early", 32'(bus.button_repeat), 32'd0);
        step(1);
        expect_bits("rep_first", 32'(bus.button_repeat), 32'd1);
        step(10);
        expect_bits("rep_second", 32'(bus.button_repeat), 32'd1);
        bus.buttons_in[0] = 1'b0;
        step(40);
        expect_bits("rep_stopped", 32'(bus.button_repeat), 32'd0);
`endif

        // Simultaneous press; ch1 released while ch0 is long-held.
        bus.buttons_in = 2'b11;
        step(10);
        expect_bits("dual_press", 32'(bus.button_pressed), 32'd3);
        step(32);
        expect_bits("dual_long", 32'(bus.button_long), 32'd3);
        step(3);
        bus.buttons_in[1] = 1'b0;
        step(10);
        expect_bits("dual_release_ch1", 32'(bus.button_released), 32'd2);
        expect_bits("dual_state_ch0", 32'(bus.button_state), 32'd1);
        step(30);
        bus.buttons_in = '0;
        step(15);

        // Random pin activity with occasional resets.
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 14) == 0) pulse_reset(2);
            bus.buttons_in = NB'($urandom);
            step(int'($urandom_range(1, 50)));
        end
        bus.buttons_in = '0;
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
